// File: rtl/bcd_ctrl_pkg.sv
// Shared definitions for the BCD counter-chain controller.
//   state_e   : controller FSM encoding, also driven onto state_o
//   BCD_MAX   : largest legal digit value
//   DIGIT_W   : width of one BCD digit
//   IDX_W     : width of a digit index
//   ld_ok()   : legality check for a single-digit load request
package bcd_ctrl_pkg;

  localparam int unsigned BCD_MAX = 9;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_LOAD  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // A load targets an existing digit with a legal BCD value.
  function automatic logic ld_ok(input logic [IDX_W-1:0]   sel,
                                 input logic [DIGIT_W-1:0] val,
                                 input int unsigned        ndig);
    return (32'(sel) < ndig) && (val <= DIGIT_W'(BCD_MAX));
  endfunction

endpackage

// File: rtl/bcd_count_ctrl_if.sv
// Board-side and chain-side signal bundle for bcd_count_ctrl.
//   Board inputs : btn_start, btn_stop, btn_load, sw_dir, sw_sel, sw_val
//   Chain input  : tc_in
//   Chain outputs: cnt_en, cnt_upd, cnt_clr, ld_stb, ld_idx, ld_val
//   Status       : state_o, wrap_flag, ld_err
// slave  : the controller (consumes board/chain inputs, drives outputs)
// master : the environment (board, digit chain, bench)
interface bcd_count_ctrl_if;
  import bcd_ctrl_pkg::*;

  logic                btn_start;
  logic                btn_stop;
  logic                btn_load;
  logic                sw_dir;
  logic [IDX_W-1:0]    sw_sel;
  logic [DIGIT_W-1:0]  sw_val;
  logic                tc_in;

  logic                cnt_en;
  logic                cnt_upd;
  logic                cnt_clr;
  logic                ld_stb;
  logic [IDX_W-1:0]    ld_idx;
  logic [DIGIT_W-1:0]  ld_val;
  logic [STATE_W-1:0]  state_o;
  logic                wrap_flag;
  logic                ld_err;

  modport slave (
    input  btn_start, btn_stop, btn_load, sw_dir, sw_sel, sw_val, tc_in,
    output cnt_en, cnt_upd, cnt_clr, ld_stb, ld_idx, ld_val,
           state_o, wrap_flag, ld_err
  );

  modport master (
    output btn_start, btn_stop, btn_load, sw_dir, sw_sel, sw_val, tc_in,
    input  cnt_en, cnt_upd, cnt_clr, ld_stb, ld_idx, ld_val,
           state_o, wrap_flag, ld_err
  );

endinterface

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector.
//   clk, rst : system clock, asynchronous active-high reset
//   btn_i    : raw asynchronous button
//   pulse_o  : one-cycle pulse, high in the second cycle after the raw edge
//              is captured (decoded from registers only)
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/bcd_count_ctrl.sv
// Sequencing controller for a chain of cascaded BCD digit counters.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : bcd_count_ctrl_if.slave
//     in  btn_start/btn_stop/btn_load : raw buttons
//     in  sw_dir/sw_sel/sw_val        : direction and load switches
//     in  tc_in                       : terminal count of the top digit
//     out cnt_en/cnt_upd/cnt_clr      : count tick, direction, chain clear
//     out ld_stb/ld_idx/ld_val        : single-digit load strobe and data
//     out state_o/wrap_flag/ld_err    : status
// Every output is a flop; commands act 3 clk cycles after the raw edge.
module bcd_count_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned STOP_ON_TC = 1
) (
  input  logic             clk,
  input  logic             rst,
  bcd_count_ctrl_if.slave  bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic start_p, stop_p, load_p;

  btn_sync_edge u_sync_start (.clk(clk), .rst(rst), .btn_i(bus.btn_start), .pulse_o(start_p));
  btn_sync_edge u_sync_stop  (.clk(clk), .rst(rst), .btn_i(bus.btn_stop),  .pulse_o(stop_p));
  btn_sync_edge u_sync_load  (.clk(clk), .rst(rst), .btn_i(bus.btn_load),  .pulse_o(load_p));

  state_e              state_q, state_d;
  state_e              ret_q,   ret_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                cnt_en_q,  cnt_en_d;
  logic                cnt_upd_q, cnt_upd_d;
  logic                cnt_clr_q, cnt_clr_d;
  logic                ld_stb_q,  ld_stb_d;
  logic [IDX_W-1:0]    ld_idx_q,  ld_idx_d;
  logic [DIGIT_W-1:0]  ld_val_q,  ld_val_d;
  logic                wrap_q,    wrap_d;
  logic                ld_err_q,  ld_err_d;

  logic wrap;
  logic enter_load;
  logic load_ok;

  // The chain only reports a wrap on the tick that actually advanced it.
  assign wrap = bus.tc_in & cnt_en_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ret_q   <= ST_IDLE;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  // Next-state logic; stop outranks load, which outranks start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!stop_p) begin
          if (load_p)       state_d = ST_LOAD;
          else if (start_p) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop_p)                         state_d = ST_PAUSE;
        else if (wrap && (STOP_ON_TC != 0)) state_d = ST_DONE;
      end
      ST_PAUSE: begin
        if (stop_p)       state_d = ST_IDLE;
        else if (load_p)  state_d = ST_LOAD;
        else if (start_p) state_d = ST_RUN;
      end
      ST_LOAD:  state_d = ret_q;
      ST_DONE: begin
        if (stop_p)       state_d = ST_IDLE;
        else if (start_p) state_d = ST_RUN;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next-values
  always_comb begin
    enter_load = (state_d == ST_LOAD) && (state_q != ST_LOAD);
    load_ok    = ld_ok(bus.sw_sel, bus.sw_val, NUM_DIGITS);

    ret_d = enter_load ? state_q : ret_q;

    // Prescaler runs only while staying in RUN, so every RUN entry
    // restarts a full TICK_DIV period.
    presc_d = '0;
    if ((state_q == ST_RUN) && (state_d == ST_RUN))
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);

    // A tick due in the cycle a stop arrives is still delivered.
    cnt_en_d = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

    cnt_upd_d = (state_q == ST_IDLE) ? bus.sw_dir : cnt_upd_q;

    cnt_clr_d = ((state_q == ST_PAUSE) && (state_d == ST_IDLE)) ||
                ((state_q == ST_DONE)  && (state_d == ST_RUN));

    ld_stb_d = enter_load && load_ok;
    ld_idx_d = ld_idx_q;
    ld_val_d = ld_val_q;
    ld_err_d = ld_err_q;
    if (enter_load) begin
      ld_err_d = !load_ok;
      if (load_ok) begin
        ld_idx_d = bus.sw_sel;
        ld_val_d = bus.sw_val;
      end
    end

    wrap_d = wrap_q;
    if ((state_d == ST_RUN) && (state_q != ST_RUN)) wrap_d = 1'b0;
    else if (wrap)                                  wrap_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      cnt_en_q  <= 1'b0;
      cnt_upd_q <= 1'b0;
      cnt_clr_q <= 1'b0;
      ld_stb_q  <= 1'b0;
      ld_idx_q  <= '0;
      ld_val_q  <= '0;
      wrap_q    <= 1'b0;
      ld_err_q  <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      cnt_en_q  <= cnt_en_d;
      cnt_upd_q <= cnt_upd_d;
      cnt_clr_q <= cnt_clr_d;
      ld_stb_q  <= ld_stb_d;
      ld_idx_q  <= ld_idx_d;
      ld_val_q  <= ld_val_d;
      wrap_q    <= wrap_d;
      ld_err_q  <= ld_err_d;
    end
  end

  assign bus.state_o   = state_q;
  assign bus.cnt_en    = cnt_en_q;
  assign bus.cnt_upd   = cnt_upd_q;
  assign bus.cnt_clr   = cnt_clr_q;
  assign bus.ld_stb    = ld_stb_q;
  assign bus.ld_idx    = ld_idx_q;
  assign bus.ld_val    = ld_val_q;
  assign bus.wrap_flag = wrap_q;
  assign bus.ld_err    = ld_err_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed self-checking bench for bcd_count_ctrl (TICK_DIV=4, NUM_DIGITS=4).
// Inputs change and outputs are sampled 2 ns after each rising clock edge.
module tb_bcd_count_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  bcd_count_ctrl_if bus ();

  bcd_count_ctrl #(
    .TICK_DIV   (4),
    .NUM_DIGITS (4),
    .STOP_ON_TC (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {state_o, cnt_en, cnt_upd, cnt_clr, ld_stb, wrap_flag, ld_err}
  function automatic logic [31:0] outs();
    return {23'd0, bus.state_o, bus.cnt_en, bus.cnt_upd, bus.cnt_clr,
            bus.ld_stb, bus.wrap_flag, bus.ld_err};
  endfunction

  initial begin
    rst = 1'b1;
    bus.btn_start = 1'b0;
    bus.btn_stop  = 1'b0;
    bus.btn_load  = 1'b0;
    bus.sw_dir    = 1'b1;
    bus.sw_sel    = 3'd0;
    bus.sw_val    = 4'd0;
    bus.tc_in     = 1'b0;

    // Reset state
    tick(2);
    chk("reset_outs", outs(), 32'h000);
    chk("reset_ldidx", {29'd0, bus.ld_idx}, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_upd", outs(), {23'd0, 3'd0, 6'b010000});

    // Start held 11 cycles: RUN 3 cycles after the edge, ticks every 4
    bus.btn_start = 1'b1;
    tick(2);
    chk("start_lat2", {29'd0, bus.state_o}, 32'd0);
    tick();
    chk("start_lat3", {29'd0, bus.state_o}, 32'd1);
    bus.sw_dir = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("run_cnt_en", {31'd0, bus.cnt_en}, {31'd0, (i % 4) == 0});
      if (i == 8) chk("run_state", {29'd0, bus.state_o}, 32'd1);
    end
    chk("run_upd_frozen", {31'd0, bus.cnt_upd}, 32'd1);
    bus.btn_start = 1'b0;

    // Stop from RUN -> PAUSE
    bus.btn_stop = 1'b1;
    tick(3);
    chk("pause_state", {29'd0, bus.state_o}, 32'd2);
    bus.btn_stop = 1'b0;
    tick(4);
    chk("pause_outs", outs(), {23'd0, 3'd2, 6'b010000});

    // Valid load in PAUSE
    bus.sw_sel = 3'd2;
    bus.sw_val = 4'd7;
    bus.btn_load = 1'b1;
    tick(2);
    chk("load_lat2", outs(), {23'd0, 3'd2, 6'b010000});
    tick();
    chk("load_stb", outs(), {23'd0, 3'd3, 6'b010100});
    chk("load_data", {25'd0, bus.ld_idx, bus.ld_val}, {25'd0, 3'd2, 4'd7});
    bus.btn_load = 1'b0;
    tick();
    chk("load_ret", outs(), {23'd0, 3'd2, 6'b010000});
    tick(3);

    // Rejected load: value 12
    bus.sw_sel = 3'd1;
    bus.sw_val = 4'd12;
    bus.btn_load = 1'b1;
    tick(3);
    chk("badval_stb", outs(), {23'd0, 3'd3, 6'b010001});
    bus.btn_load = 1'b0;
    tick();
    chk("badval_ret", outs(), {23'd0, 3'd2, 6'b010001});
    tick(3);

    // Rejected load: index 5; previous load data held
    bus.sw_sel = 3'd5;
    bus.sw_val = 4'd3;
    bus.btn_load = 1'b1;
    tick(3);
    chk("badsel_stb", outs(), {23'd0, 3'd3, 6'b010001});
    chk("badsel_data", {25'd0, bus.ld_idx, bus.ld_val}, {25'd0, 3'd2, 4'd7});
    bus.btn_load = 1'b0;
    tick(4);

    // Valid load at boundary (idx 3, value 9) clears ld_err
    bus.sw_sel = 3'd3;
    bus.sw_val = 4'd9;
    bus.btn_load = 1'b1;
    tick(3);
    chk("goodld_stb", outs(), {23'd0, 3'd3, 6'b010100});
    chk("goodld_data", {25'd0, bus.ld_idx, bus.ld_val}, {25'd0, 3'd3, 4'd9});
    bus.btn_load = 1'b0;
    tick(4);

    // Wrap: resume with tc_in held
    bus.tc_in = 1'b1;
    bus.btn_start = 1'b1;
    tick(3);
    chk("wrap_run", outs(), {23'd0, 3'd1, 6'b010000});
    bus.btn_start = 1'b0;
    tick(3);
    chk("wrap_pre", {31'd0, bus.cnt_en}, 32'd0);
    tick();
    chk("wrap_tick", outs(), {23'd0, 3'd1, 6'b110000});
    tick();
    chk("wrap_done", outs(), {23'd0, 3'd4, 6'b010010});
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("done_no_en", outs(), {23'd0, 3'd4, 6'b010010});
    end
    bus.tc_in = 1'b0;

    // Start from DONE: clear pulse, RUN, wrap_flag cleared
    bus.btn_start = 1'b1;
    tick(3);
    chk("restart_clr", outs(), {23'd0, 3'd1, 6'b011000});
    tick();
    chk("restart_post", outs(), {23'd0, 3'd1, 6'b010000});
    bus.btn_start = 1'b0;
    tick(4);

    // Stop and start edges together in RUN -> PAUSE
    bus.btn_start = 1'b1;
    bus.btn_stop  = 1'b1;
    tick(3);
    chk("stop_prio", {29'd0, bus.state_o}, 32'd2);
    bus.btn_start = 1'b0;
    bus.btn_stop  = 1'b0;
    tick(4);

    // Stop from PAUSE -> IDLE with clear; direction reloads in IDLE
    bus.btn_stop = 1'b1;
    tick(3);
    chk("stop_idle_clr", outs(), {23'd0, 3'd0, 6'b011000});
    tick();
    chk("idle_upd_reload", outs(), {23'd0, 3'd0, 6'b000000});
    bus.btn_stop = 1'b0;
    tick(4);

    // Reset asserted during LOAD
    bus.sw_sel = 3'd0;
    bus.sw_val = 4'd5;
    bus.btn_load = 1'b1;
    tick(3);
    chk("rstld_stb", outs(), {23'd0, 3'd3, 6'b000100});
    rst = 1'b1;
    #1;
    chk("rstld_async", outs(), 32'h000);
    chk("rstld_data", {25'd0, bus.ld_idx, bus.ld_val}, 32'd0);
    bus.btn_load = 1'b0;
    tick();
    rst = 1'b0;
    tick(2);
    chk("post_rst", {29'd0, bus.state_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
